// File: rtl/microcode_sequencer.sv
// Micro-PC sequencer for the multi-cycle RISC-V control unit.
// Steps the microcode ROM address and flags retire, illegal and timeout.
module microcode_sequencer #(
  parameter int CNT_W      = 16,
  parameter int WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic [3:0]       upc,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] instr_count
);

  localparam int WW = $clog2(WAIT_LIMIT + 1);
  localparam logic [WW-1:0] LIMIT = WW'(WAIT_LIMIT);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    ALUWB    = 4'd7,
    EXECI    = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [6:0]    op_q;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic          retire;
  logic          illegal;
  logic          waiting;

  assign upc = state;

  // Next micro-state plus retire/illegal/wait qualifiers for this state.
  always_comb begin
    state_nxt = FETCH;
    retire    = 1'b0;
    illegal   = 1'b0;
    waiting   = 1'b0;
    case (state)
      FETCH: begin
        waiting   = 1'b1;
        state_nxt = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        case (op)
          OP_LW,
          OP_SW:   state_nxt = MEMADR;
          OP_R:    state_nxt = EXECR;
          OP_I:    state_nxt = EXECI;
          OP_JAL:  state_nxt = JAL;
          OP_BEQ:  state_nxt = BEQ;
          default: begin
            state_nxt = FETCH;
            illegal   = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        state_nxt = (op_q == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        waiting   = 1'b1;
        state_nxt = mem_ready ? MEMWB : MEMREAD;
      end
      MEMWRITE: begin
        waiting = 1'b1;
        if (mem_ready) begin
          state_nxt = FETCH;
          retire    = 1'b1;
        end else begin
          state_nxt = MEMWRITE;
        end
      end
      EXECR,
      EXECI,
      JAL: begin
        state_nxt = ALUWB;
      end
      MEMWB,
      ALUWB,
      BEQ: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      default: begin
        state_nxt = FETCH;
      end
    endcase
  end

  // Stall counter: only a stalled wait state counts; anything else clears.
  always_comb begin
    wait_nxt = '0;
    if (waiting && !mem_ready) begin
      wait_nxt = (wait_cnt == LIMIT) ? wait_cnt : wait_cnt + WW'(1);
    end
  end

  // Sequencer state, registered pulses, retire counter and timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      op_q        <= '0;
      wait_cnt    <= '0;
      instr_done  <= 1'b0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
      instr_count <= '0;
    end else begin
      instr_done <= 1'b0;
      illegal_op <= 1'b0;
      if (en) begin
        state      <= state_nxt;
        wait_cnt   <= wait_nxt;
        instr_done <= retire;
        illegal_op <= illegal;
        if (state == DECODE) begin
          op_q <= op;
        end
        if (retire) begin
          instr_count <= instr_count + CNT_W'(1);
        end
        if (wait_nxt == LIMIT) begin
          mem_timeout <= 1'b1;
        end
      end
    end
  end

endmodule
